arbitro_ram_caracteres: RTL
===========================

# arbitro_ram_caracteres

Arbiter for the single-port character RAM holding the on-screen text (time, date and timer digits). It shares the RAM between the VGA text renderer (reader, paced by the sync generator's pixel tick) and the RTC update logic (writer). Writes are buffered in a small FIFO and drained in free RAM cycles. Reads have priority during active video; writes have priority during blanking.

## Interface
- ADDR_W, 6, character-cell address width (64 cells)
- DATA_W, 8, character code width
- FIFO_DEPTH, 4, write FIFO entries (power of two, ≥2)

- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-low reset
- video_on  in  1  active-video flag from the sync generator
- rd_req  in  1  renderer read request, one cycle per read
- rd_addr  in  ADDR_W  read address, sampled with rd_req
- rd_data  out  DATA_W  read result
- rd_valid  out  1  one-cycle pulse, rd_data valid
- wr_req  in  1  RTC write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ack  out  1  one-cycle pulse, previous-cycle write accepted
- wr_full  out  1  FIFO full
- busy  out  1  FIFO not empty
- overflow  out  1  sticky: a write was dropped
- ram_en, ram_we  out  1 each  RAM enable / write enable
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data, synchronous (one-cycle latency)

## Operation
- Reset (reset=0): FIFO empty; all outputs 0; read pipeline cleared; overflow cleared. Applies immediately and asynchronously.
- At most one RAM access per cycle. The arbiter decides in cycle N and registers the RAM port outputs, which are valid in N+1.
- Arbitration in cycle N:
  - video_on=1: rd_req wins. A FIFO-head write issues only if rd_req=0.
  - video_on=0: a non-empty FIFO wins. rd_req is serviced only if the FIFO is empty. A losing read is dropped: no rd_valid, no retry.
  - Idle cycle: ram_en=0, ram_we=0. ram_addr and ram_din hold their last values.
- Read grant: ram_en=1, ram_we=0, ram_addr=rd_addr in N+1. ram_dout is captured at the end of N+2. rd_data and rd_valid are driven in N+3. Back-to-back reads are fully pipelined, one per cycle.
- Write grant: ram_en=1, ram_we=1, ram_addr/ram_din = FIFO head in N+1. The FIFO pops at the end of N.
- FIFO push: wr_req=1 and not full in cycle N → entry stored at the end of N; wr_ack=1 in N+1.
- wr_req=1 while full → entry dropped, no wr_ack, overflow set (sticky until reset).
- Full is evaluated before any same-cycle pop, so a pop never frees a slot for a same-cycle push.
- No bypass: a write pushed in cycle N can issue no earlier than N+1 (RAM port in N+2).
- Writes drain in FIFO order.
- Counters: read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. The occupancy counter is log2(FIFO_DEPTH)+1 bits. wr_full = (count==FIFO_DEPTH); busy = (count!=0).
- Read-after-write to the same address: the RAM returns the old value if the write issues in the same or a later cycle. No forwarding.

## Timing
- Read latency: rd_req sampled at N → rd_valid at N+3. This fits inside the 4-clock pixel period.
- Write acceptance latency is 1 cycle (wr_ack). Minimum push-to-RAM write is 2 cycles.
- During a continuous read stream with video_on=1, writes wait until the first cycle with rd_req=0 or video_on=0.
- Reset mid-operation: in-flight reads never produce rd_valid; queued writes are discarded; RAM port returns to idle with no partial write.

## Test plan
- Reset: hold reset=0 with rd_req/wr_req toggling → all outputs 0. Release, then rd_req with rd_addr=5 (RAM[5]=0x31) → rd_valid with rd_data=0x31 exactly 3 cycles later.
- Collision, video_on=1: rd_req (addr 2) and a pending write (addr 7, 0x41) in the same cycle → read issues first; write issues the next cycle (ram_we=1, ram_addr=7). Rewrite during blanking → write first, read dropped, no rd_valid.
- Fill: 5 consecutive wr_req with video_on=1 and continuous rd_req → 4 wr_acks, wr_full=1, overflow=1. Drop video_on → 4 writes in order, then busy=0, wr_full=0.
- Full plus pop: FIFO full, video_on=0, wr_req asserted → pop occurs, push refused, overflow=1. Next cycle wr_req → accepted, wr_ack pulses.
- Pipelining: 8 back-to-back reads, addrs 0..7 → 8 consecutive rd_valid pulses with matching data, starting 3 cycles after the first request.
- Async reset mid-stream: reset=0 one cycle after two reads and three pushed writes → no rd_valid, busy=0, no RAM write after reset release.

Source files
------------

// File: rtl/arbitro_ram_caracteres.sv
// ---------------------------------------------------------------------------
// arbitro_ram_caracteres
//   Shares the single-port character RAM (on-screen time/date/timer text)
//   between the VGA text renderer (reader) and the RTC update logic
//   (writer). RTC writes are queued in a small FIFO and drained in free RAM
//   cycles. Reads win during active video; queued writes win during blanking.
//
// Ports
//   clk, reset          system clock, asynchronous active-low reset
//   video_on            active-video flag (selects the priority)
//   rd_req/rd_addr      renderer read request (one cycle per read)
//   rd_data/rd_valid    read result, 3 cycles after rd_req
//   wr_req/wr_addr/     RTC write request and payload
//   wr_data
//   wr_ack              pulse: write of the previous cycle was queued
//   wr_full/busy        FIFO full / FIFO not empty
//   overflow            sticky: a write was dropped because the FIFO was full
//   ram_en/ram_we/      registered RAM port
//   ram_addr/ram_din
//   ram_dout            RAM read data, one-cycle latency
// ---------------------------------------------------------------------------
module arbitro_ram_caracteres #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              video_on,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_full,
    output logic              busy,
    output logic              overflow,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int STAGES = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_ent_t;

    wr_ent_t           r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [STAGES:0]   r_vld_pipe;

    logic    w_full;
    logic    w_empty;
    logic    w_push;
    logic    w_rd_grant;
    logic    w_wr_grant;
    wr_ent_t w_head;

    // Full/empty come from the registered count, so a same-cycle pop never
    // frees a slot for a push, and a same-cycle push is never visible to
    // the arbiter (no bypass).
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = wr_req & ~w_full;
    assign w_head  = r_fifo[r_rptr];

    assign wr_full  = w_full;
    assign busy     = ~w_empty;
    assign rd_valid = r_vld_pipe[STAGES];

    always_comb begin
        w_rd_grant = 1'b0;
        w_wr_grant = 1'b0;
        if (video_on) begin
            w_rd_grant = rd_req;
            w_wr_grant = ~rd_req & ~w_empty;
        end else begin
            // Blanking: a losing read is simply dropped, never retried.
            w_wr_grant = ~w_empty;
            w_rd_grant = rd_req & w_empty;
        end
    end

    // FIFO storage needs no reset: only entries covered by r_count are read.
    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wptr] <= '{addr: wr_addr, data: wr_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            wr_ack   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PTR_W'(1);
            if (w_wr_grant)
                r_rptr <= r_rptr + PTR_W'(1);
            r_count  <= r_count + CNT_W'(w_push) - CNT_W'(w_wr_grant);
            wr_ack   <= w_push;
            overflow <= overflow | (wr_req & w_full);
        end
    end

    // RAM port: on idle cycles only the strobes drop; address and write
    // data keep their last values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else if (w_rd_grant) begin
            ram_en   <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= rd_addr;
        end else if (w_wr_grant) begin
            ram_en   <= 1'b1;
            ram_we   <= 1'b1;
            ram_addr <= w_head.addr;
            ram_din  <= w_head.data;
        end else begin
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
        end
    end

    // Read pipeline: [0] RAM port driven, [1] ram_dout valid, [2] rd_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld_pipe <= '0;
            rd_data    <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:0], w_rd_grant};
            if (r_vld_pipe[STAGES-1])
                rd_data <= ram_dout;
        end
    end

endmodule
